fetch_controller: RTL

//  Sequences instruction fetch for the RISC datapath. Each fetch runs in this order:
//  PC -> memory read -> instruction register load -> PC increment.
//  It then hands the decoded instruction to the execute FSM with a start/done handshake.

---
 rtl/fetch_controller_if.sv | 56 +++++
 rtl/fetch_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// Bundle between the fetch controller and the datapath/execute side:
// memory handshake, IR opcode, execute handshake, datapath controls and status.
interface fetch_controller_if #(
    parameter int unsigned CNT_W = 16
);
    // Datapath / execute side -> controller
    logic             mem_ready;
    logic [2:0]       ir_opcode;
    logic             exec_done;

    // Controller -> datapath / execute side
    logic [1:0]       mem_cmd;
    logic             addr_sel;
    logic             load_ir;
    logic             load_pc;
    logic             reset_pc;
    logic             exec_start;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] fetch_count;
    logic [2:0]       state;

    // The fetch controller owns the control outputs.
    modport master (
        input  mem_ready,
        input  ir_opcode,
        input  exec_done,
        output mem_cmd,
        output addr_sel,
        output load_ir,
        output load_pc,
        output reset_pc,
        output exec_start,
        output halted,
        output timeout_err,
        output fetch_count,
        output state
    );

    // Datapath / execute FSM view.
    modport slave (
        output mem_ready,
        output ir_opcode,
        output exec_done,
        input  mem_cmd,
        input  addr_sel,
        input  load_ir,
        input  load_pc,
        input  reset_pc,
        input  exec_start,
        input  halted,
        input  timeout_err,
        input  fetch_count,
        input  state
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC -> memory read -> IR load -> PC increment,
// then a start/done handshake with the execute FSM. Stops on the HALT opcode
// and on a memory timeout; both conditions hold until reset.
module fetch_controller #(
    parameter logic [2:0]  HALT_OPCODE = 3'b111,
    parameter int unsigned TIMEOUT     = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    fetch_controller_if.master bus
);

    // State encodings are visible on the debug port, so they are fixed values.
    localparam logic [2:0] StReset    = 3'd0;
    localparam logic [2:0] StFetch    = 3'd1;
    localparam logic [2:0] StLoadIr   = 3'd2;
    localparam logic [2:0] StUpdatePc = 3'd3;
    localparam logic [2:0] StDecode   = 3'd4;
    localparam logic [2:0] StExec     = 3'd5;
    localparam logic [2:0] StHalt     = 3'd6;
    localparam logic [2:0] StErr      = 3'd7;

    localparam int unsigned   WaitW    = $clog2(TIMEOUT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    localparam logic [1:0] MemNone = 2'b00;
    localparam logic [1:0] MemRead = 2'b01;

    // A one-cycle timeout window would make the wait counter degenerate.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("fetch_controller: TIMEOUT must be at least 2");
    end

    logic [2:0]       state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic is_halt_op;
    assign is_halt_op = (bus.ir_opcode == HALT_OPCODE);

    // Next-state decision; exec_done and mem_ready only matter in their own states.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:    state_d = StFetch;
            StFetch: begin
                // A late mem_ready on the last allowed cycle still counts.
                if (bus.mem_ready) begin
                    state_d = StLoadIr;
                end else if (wait_q == WaitLast) begin
                    state_d = StErr;
                end
            end
            StLoadIr:   state_d = StUpdatePc;
            StUpdatePc: state_d = StDecode;
            StDecode:   state_d = is_halt_op ? StHalt : StExec;
            StExec: begin
                if (bus.exec_done) begin
                    state_d = StFetch;
                end
            end
            StHalt:     state_d = StHalt;
            StErr:      state_d = StErr;
        endcase
    end

    // Wait counter runs only while in FETCH, so it is zero on every entry.
    always_comb begin
        wait_d = '0;
        if (state_q == StFetch) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Saturating count of IR loads.
    always_comb begin
        count_d = count_q;
        if ((state_q == StLoadIr) && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // State and counters; reset dominates anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReset;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Control outputs decoded from the registered state; exec_start also looks at the opcode.
    always_comb begin
        bus.mem_cmd     = MemNone;
        bus.addr_sel    = 1'b0;
        bus.load_ir     = 1'b0;
        bus.load_pc     = 1'b0;
        bus.reset_pc    = 1'b0;
        bus.exec_start  = 1'b0;
        bus.halted      = 1'b0;
        bus.timeout_err = 1'b0;
        unique case (state_q)
            StReset: begin
                bus.reset_pc = 1'b1;
                bus.load_pc  = 1'b1;
            end
            StFetch: begin
                bus.mem_cmd  = MemRead;
                bus.addr_sel = 1'b1;
            end
            StLoadIr: begin
                bus.mem_cmd  = MemRead;
                bus.addr_sel = 1'b1;
                bus.load_ir  = 1'b1;
            end
            StUpdatePc: begin
                bus.load_pc = 1'b1;
            end
            StDecode: begin
                bus.exec_start = !is_halt_op;
            end
            StExec: begin
            end
            StHalt: begin
                bus.halted = 1'b1;
            end
            StErr: begin
                bus.timeout_err = 1'b1;
            end
        endcase
    end

    assign bus.fetch_count = count_q;
    assign bus.state       = state_q;

    // Sanity properties: exec_start is a single-cycle pulse, and the two stop flags exclude.
    property p_start_pulse;
        @(posedge clk) disable iff (reset) bus.exec_start |=> !bus.exec_start;
    endproperty
    a_start_pulse: assert property (p_start_pulse);

    property p_flags_exclusive;
        @(posedge clk) disable iff (reset) !(bus.halted && bus.timeout_err);
    endproperty
    a_flags_exclusive: assert property (p_flags_exclusive);

endmodule
